// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier feed path: default widths, splitter
// state encoding and the two-lowest-set-bits extraction rule.
package mult_pkg;

    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } split_state_e;

    // Returns {chunk, last}: chunk holds the two lowest set bits of rem,
    // last is set when nothing remains in rem after removing chunk.
    function automatic logic [B_W_DEF:0] pop_two_lsb(input logic [B_W_DEF-1:0] rem);
        logic [B_W_DEF-1:0] lo1;
        logic [B_W_DEF-1:0] rest;
        logic [B_W_DEF-1:0] lo2;
        logic [B_W_DEF-1:0] chunk;
        lo1   = rem & (-rem);
        rest  = rem ^ lo1;
        lo2   = rest & (-rest);
        chunk = lo1 | lo2;
        return {chunk, ((rem ^ chunk) == '0)};
    endfunction

endpackage

// File: rtl/pair_pick.sv
// Combinational picker: isolates the two lowest set bits of rem and flags
// whether they exhaust it.
module pair_pick #(
    parameter int B_W = 16
) (
    input  logic [B_W-1:0] rem,
    output logic [B_W-1:0] chunk,
    output logic           last
);

    logic [B_W-1:0] lo1;
    logic [B_W-1:0] rest;
    logic [B_W-1:0] lo2;

    // Two's-complement AND trick: x & -x keeps only the lowest set bit.
    assign lo1   = rem & (-rem);
    assign rest  = rem ^ lo1;
    assign lo2   = rest & (-rest);
    assign chunk = lo1 | lo2;
    assign last  = ((rem ^ chunk) == '0);

endmodule

// File: rtl/bit_pair_splitter.sv
// Splits multiplier b into a sequence of chunks with at most two set bits
// each, LSB first, pairing every chunk with the unchanged multiplicand a.
module bit_pair_splitter
    import mult_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [A_W-1:0] out_a,
    output logic [B_W-1:0] out_b,
    output logic           out_last
);

    split_state_e   state_reg, state_next;
    logic           rdy_reg, rdy_next;
    logic           vld_reg, vld_next;
    logic           last_reg, last_next;
    logic [A_W-1:0] a_reg, a_next;
    logic [B_W-1:0] rem_reg, rem_next;
    logic [B_W-1:0] b_reg, b_next;

    logic [B_W-1:0] pick_rem;
    logic [B_W-1:0] pick_chunk;
    logic           pick_last;

    // In IDLE the picker looks at the fresh operand; in EMIT at what is left
    // once the beat currently on out_b has been removed.
    assign pick_rem = (state_reg == IDLE) ? in_b : (rem_reg ^ b_reg);

    pair_pick #(
        .B_W(B_W)
    ) u_pair_pick (
        .rem  (pick_rem),
        .chunk(pick_chunk),
        .last (pick_last)
    );

    always_comb begin
        state_next = state_reg;
        rdy_next   = rdy_reg;
        vld_next   = vld_reg;
        last_next  = last_reg;
        a_next     = a_reg;
        rem_next   = rem_reg;
        b_next     = b_reg;
        case (state_reg)
            IDLE: begin
                rdy_next = 1'b1;
                if (in_vld && rdy_reg) begin
                    a_next     = in_a;
                    rem_next   = in_b;
                    b_next     = pick_chunk;
                    last_next  = pick_last;
                    vld_next   = 1'b1;
                    rdy_next   = 1'b0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_rdy) begin
                    if (last_reg) begin
                        vld_next   = 1'b0;
                        last_next  = 1'b0;
                        rdy_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rem_next  = rem_reg ^ b_reg;
                        b_next    = pick_chunk;
                        last_next = pick_last;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rdy_reg   <= 1'b0;
            vld_reg   <= 1'b0;
            last_reg  <= 1'b0;
            a_reg     <= '0;
            rem_reg   <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            rdy_reg   <= rdy_next;
            vld_reg   <= vld_next;
            last_reg  <= last_next;
            a_reg     <= a_next;
            rem_reg   <= rem_next;
            b_reg     <= b_next;
        end
    end

    assign in_rdy   = rdy_reg;
    assign out_vld  = vld_reg;
    assign out_last = last_reg;
    assign out_a    = a_reg;
    assign out_b    = b_reg;

endmodule

// File: tb/tb_bit_pair_splitter.sv
// Scoreboard bench for bit_pair_splitter: a bit-scanning reference model
// queues the expected beats, a negedge monitor pops and compares them.
module tb_bit_pair_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_last;

    bit_pair_splitter #(
        .A_W(16),
        .B_W(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_a    (in_a),
        .in_b    (in_b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_a   (out_a),
        .out_b   (out_b),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] prod_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          last_done_cyc = -100;
    int          rdy_mode = 0;
    logic [31:0] sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan b from bit 0 upward, grouping set bits two at a time.
    task automatic model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] chunks[$];
        logic [15:0] ch;
        int          n;
        ch = '0;
        n  = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                ch[i] = 1'b1;
                n++;
                if (n == 2) begin
                    chunks.push_back(ch);
                    ch = '0;
                    n  = 0;
                end
            end
        end
        if (n == 1 || chunks.size() == 0) chunks.push_back(ch);
        for (int i = 0; i < chunks.size(); i++)
            sb.push_back('{a: a, b: chunks[i], last: (i == chunks.size() - 1)});
        prod_q.push_back(32'(a) * 32'(b));
    endtask

    // Called #1 after a clock edge; returns #1 after the handshake edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit hold);
        int n;
        n      = 0;
        in_a   = a;
        in_b   = b;
        in_vld = 1'b1;
        while (!in_rdy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_rdy) begin
            total++;
            bad++;
            $display("FAIL in_handshake_timeout actual=in_rdy_low required=in_rdy_high");
            in_vld = 1'b0;
            return;
        end
        model(a, b);
        hs_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (!hold) in_vld = 1'b0;
        check("first_beat_latency", {63'd0, out_vld}, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_vld) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        check("drain_out_vld", {63'd0, out_vld}, 64'd0);
    endtask

    // out_rdy pattern: 0 always ready, 1 random, 2 five stall cycles per beat.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!out_vld) begin
                        out_rdy = 1'b0;
                        cnt = 0;
                    end else if (cnt < 5) begin
                        out_rdy = 1'b0;
                        cnt++;
                    end else begin
                        out_rdy = 1'b1;
                        cnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: compares every accepted beat and checks stall stability.
    initial begin
        beat_t       e;
        logic [32:0] snap;
        bit          stall_ok;
        stall_ok = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_ok = 1'b0;
                continue;
            end
            check("rdy_vld_exclusive", {63'd0, in_rdy && out_vld}, 64'd0);
            if (stall_ok && out_vld)
                check("stall_stable", {31'd0, out_a, out_b, out_last}, {31'd0, snap});
            if (out_vld && out_rdy) begin
                $display("beat a=%0h b=%04h last=%0b", out_a, out_b, out_last);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=%04h required=none", out_b);
                end else begin
                    e = sb.pop_front();
                    check("beat_a", 64'(out_a), 64'(e.a));
                    check("beat_b", 64'(out_b), 64'(e.b));
                    check("beat_last", {63'd0, out_last}, {63'd0, e.last});
                    sum = sum + 32'(out_a) * 32'(out_b);
                    if (e.last) begin
                        check("seq_product_sum", 64'(sum), 64'(prod_q.pop_front()));
                        sum = '0;
                        last_done_cyc = cyc + 1;
                    end
                end
            end
            stall_ok = out_vld && !out_rdy;
            snap = {out_a, out_b, out_last};
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        #2;
        check("reset_in_rdy", {63'd0, in_rdy}, 64'd0);
        check("reset_out_vld", {63'd0, out_vld}, 64'd0);
        check("reset_out_last", {63'd0, out_last}, 64'd0);
        check("reset_out_ab", {32'd0, out_a, out_b}, 64'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("in_rdy_before_edge", {63'd0, in_rdy}, 64'd0);
        @(posedge clk);
        #1;
        check("in_rdy_after_release", {63'd0, in_rdy}, 64'd1);

        // Zero multiplier and single-beat cases, always ready.
        rdy_mode = 0;
        send(16'd7, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("zero_b_turnaround_in_rdy", {63'd0, in_rdy}, 64'd1);
        send(16'd3, 16'h0005, 1'b0);
        send(16'd3, 16'h8001, 1'b0);
        send(16'd3, 16'h8000, 1'b0);
        send(16'd9, 16'h00F0, 1'b0);
        wait_idle();

        // Back-to-back pairs with in_vld held high.
        send(16'd2, 16'h0007, 1'b1);
        send(16'd4, 16'h0100, 1'b0);
        check("back_to_back_gap", 64'(hs_cyc - last_done_cyc), 64'd1);
        wait_idle();

        // Dense operand with long stalls before every accept.
        rdy_mode = 2;
        send(16'd5, 16'hFFFF, 1'b0);
        wait_idle();

        // Reset after two beats of a dense sequence.
        rdy_mode = 0;
        send(16'd2, 16'hFFFF, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_vld", {63'd0, out_vld}, 64'd0);
        check("midrst_out_last", {63'd0, out_last}, 64'd0);
        check("midrst_in_rdy", {63'd0, in_rdy}, 64'd0);
        sb.delete();
        prod_q.delete();
        sum = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midrst_held_out_vld", {63'd0, out_vld}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_rdy_low", {63'd0, in_rdy}, 64'd0);
        @(posedge clk);
        #1;
        check("midrst_release_in_rdy_high", {63'd0, in_rdy}, 64'd1);
        check("midrst_no_stale_beat", {63'd0, out_vld}, 64'd0);
        send(16'd2, 16'h0001, 1'b0);
        wait_idle();

        // Randomized operands under random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = 16'h1 << $urandom_range(0, 15);
                2: rb = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: rb = 16'($urandom) | 16'($urandom);
            endcase
            send(ra, rb, 1'b0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
